// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, big-endian 32-bit data memory, sub-word stores by
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to report misaligned requests as errors.
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRd   = 2'd1;
  localparam logic [1:0] StWr   = 2'd2;
  localparam logic [1:0] StResp = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           word_q;

  logic                  mis;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] access_addr;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [31:0]           load_ext;
  logic [31:0]           merged;
  logic [31:0]           store_word;
  logic                  err;

  // Misalignment is judged from the registered request.
  assign mis = ((size_q == 2'b01) && addr_q[0]) || (size_q[1] && (addr_q[1:0] != 2'b00));

  // Misaligned accesses (when not trapped) use the raw address at lane offset 0.
  assign off         = mis ? 2'b00 : addr_q[1:0];
  assign access_addr = mis ? addr_q : {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
  assign err     = mis;
`else
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_we && req_size[1]) state_d = StWr;
          else                       state_d = StRd;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_mis) state_d = StResp;
`endif
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      word_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req_valid) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      if (state_q == StRd) word_q <= mem_rdata;
    end
  end

  // Lane selection: offset 0 is the most significant byte (big-endian).
  always_comb begin
    case (off)
      2'd0:    lane_byte = word_q[31:24];
      2'd1:    lane_byte = word_q[23:16];
      2'd2:    lane_byte = word_q[15:8];
      default: lane_byte = word_q[7:0];
    endcase
    lane_half = off[1] ? word_q[15:0] : word_q[31:16];
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & lane_byte[7]}}, lane_byte};
      2'b01:   load_ext = {{16{signed_q & lane_half[15]}}, lane_half};
      default: load_ext = word_q;
    endcase
  end

  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) begin
      case (off)
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (size_q == 2'b01) begin
      if (off[1]) merged[15:0]  = wdata_q[15:0];
      else        merged[31:16] = wdata_q[15:0];
    end
    store_word = size_q[1] ? wdata_q : merged;
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_read   = (state_q == StRd);
    mem_write  = (state_q == StWr) && !rst;
    mem_addr   = ((state_q == StRd) || (state_q == StWr)) ? access_addr : '0;
    mem_wdata  = (state_q == StWr) ? store_word : 32'h0;
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err;
    resp_rdata = ((state_q == StResp) && !we_q && !err) ? load_ext : 32'h0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec cases plus randomized traffic checked
// against a byte-array memory model. Honours LSU_MISALIGN_TRAP_EN like the design.
module tb_load_store_unit;

  localparam int AW = 10;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid, resp_err, mem_read, mem_write;
  logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  int            lat, nrd, nwr;
  logic [31:0]   rdata, wr_data;
  logic          err;
  logic [AW-1:0] rd_addr, wr_addr;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Big-endian data memory; address arithmetic wraps at 10 bits.
  assign mem_rdata = {mem[mem_addr], mem[mem_addr + 10'd1], mem[mem_addr + 10'd2],
                      mem[mem_addr + 10'd3]};

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr]         = mem_wdata[31:24];
      mem[mem_addr + 10'd1] = mem_wdata[23:16];
      mem[mem_addr + 10'd2] = mem_wdata[15:8];
      mem[mem_addr + 10'd3] = mem_wdata[7:0];
    end
  end

  // Reference: an access of n bytes touches bytes addr..addr+n-1, most significant first.
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] size, input logic [AW-1:0] addr);
    return (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [AW-1:0] addr);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(int'(addr) + i) % 1024]);
    if (n == 1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && sgn && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [AW-1:0] addr,
                             input logic [31:0] wdata);
    int n;
    n = nbytes(size);
    for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 1024] = 8'(wdata >> (8 * (n - 1 - i)));
  endtask

  task automatic poke_word(input logic [AW-1:0] addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      mem[(int'(addr) + i) % 1024]     = 8'(w >> (8 * (3 - i)));
      ref_mem[(int'(addr) + i) % 1024] = 8'(w >> (8 * (3 - i)));
    end
  endtask

  // Issue one request and observe it at each negedge until the response pulse.
  task automatic do_op(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] addr, input logic [31:0] wdata, input bit noise);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_idle: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    lat = 0; nrd = 0; nwr = 0; rdata = 32'h0; err = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (noise) begin
        req_valid = 1'b1; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = 10'($urandom); req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      if (mem_read)  begin nrd++; rd_addr = mem_addr; end
      if (mem_write) begin nwr++; wr_addr = mem_addr; wr_data = mem_wdata; end
      if (!mem_read && !mem_write) begin
        n_checks++;
        if (mem_addr !== '0) begin
          n_fail++; $display("FAIL idle_addr: mem_addr=%h required 0", mem_addr);
        end
      end
      if (!mem_write) begin
        n_checks++;
        if (mem_wdata !== 32'h0) begin
          n_fail++; $display("FAIL idle_wdata: mem_wdata=%h required 0", mem_wdata);
        end
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
      n_checks++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL busy_ready: req_ready=%b required 0 at cycle %0d", req_ready, c);
      end
    end
    req_valid = 1'b0;
    n_checks++;
    if (lat == 0) begin
      n_fail++; $display("FAIL timeout: no resp_valid within 8 cycles");
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_resp: ready=%b valid=%b required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL rst_ready: got %b required 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid: got %b required 0", resp_valid); end
    n_checks++; if (resp_rdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_rdata: got %h required 0", resp_rdata); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_err: got %b required 0", resp_err); end
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++;
      $display("FAIL rst_mem_en: rd=%b wr=%b required 0 0", mem_read, mem_write); end
    n_checks++; if (mem_addr !== '0 || mem_wdata !== 32'h0) begin n_fail++;
      $display("FAIL rst_mem_bus: addr=%h wdata=%h required 0 0", mem_addr, mem_wdata); end
  endtask

  task automatic test_loads;
    logic [1:0]    sz  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic          sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [AW-1:0] ad  [5] = '{10'h020, 10'h020, 10'h023, 10'h020, 10'h022};
    logic [31:0]   exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001, 32'hFFFF_80FF,
                               32'h0000_7F01};
    poke_word(10'h020, 32'h80FF_7F01);
    for (int i = 0; i < 5; i++) begin
      do_op(1'b0, sz[i], sg[i], ad[i], 32'h0, 1'b0);
      n_checks++; if (rdata !== exp[i]) begin n_fail++;
        $display("FAIL load_data[%0d]: got %h required %h", i, rdata, exp[i]); end
      n_checks++; if (lat != 2 || err !== 1'b0) begin n_fail++;
        $display("FAIL load_lat[%0d]: lat=%0d err=%b required 2 0", i, lat, err); end
      n_checks++; if (nrd != 1 || nwr != 0 || rd_addr !== 10'h020) begin n_fail++;
        $display("FAIL load_bus[%0d]: rd=%0d wr=%0d addr=%h required 1 0 020", i, nrd, nwr,
                 rd_addr); end
    end
  endtask

  task automatic test_subword_store;
    poke_word(10'h020, 32'h80FF_7F01);
    do_op(1'b1, 2'b00, 1'b0, 10'h021, 32'h0000_00AA, 1'b0);
    n_checks++; if (lat != 3 || nrd != 1 || nwr != 1) begin n_fail++;
      $display("FAIL sb_shape: lat=%0d rd=%0d wr=%0d required 3 1 1", lat, nrd, nwr); end
    n_checks++; if (wr_addr !== 10'h020 || wr_data !== 32'h80AA_7F01) begin n_fail++;
      $display("FAIL sb_write: addr=%h data=%h required 020 80aa7f01", wr_addr, wr_data); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++;
      $display("FAIL sb_rdata: got %h required 0", rdata); end
    do_op(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 1'b0);
    n_checks++; if (rdata !== 32'h80AA_7F01) begin n_fail++;
      $display("FAIL sb_readback: got %h required 80aa7f01", rdata); end
  endtask

  task automatic test_word_store;
    do_op(1'b1, 2'b10, 1'b0, 10'h030, 32'hDEAD_BEEF, 1'b0);
    n_checks++; if (lat != 2 || nrd != 0 || nwr != 1) begin n_fail++;
      $display("FAIL sw_shape: lat=%0d rd=%0d wr=%0d required 2 0 1", lat, nrd, nwr); end
    n_checks++; if (wr_addr !== 10'h030 || wr_data !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL sw_write: addr=%h data=%h required 030 deadbeef", wr_addr, wr_data); end
  endtask

  task automatic test_misaligned;
    do_op(1'b0, 2'b10, 1'b0, 10'h031, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0 || lat != 1) begin n_fail++;
      $display("FAIL mis_trap: err=%b rdata=%h lat=%0d required 1 0 1", err, rdata, lat); end
    n_checks++; if (nrd != 0 || nwr != 0) begin n_fail++;
      $display("FAIL mis_trap_bus: rd=%0d wr=%0d required 0 0", nrd, nwr); end
`else
    n_checks++; if (err !== 1'b0 || lat != 2) begin n_fail++;
      $display("FAIL mis_noerr: err=%b lat=%0d required 0 2", err, lat); end
    n_checks++; if (nrd != 1 || rd_addr !== 10'h031) begin n_fail++;
      $display("FAIL mis_addr: rd=%0d addr=%h required 1 031", nrd, rd_addr); end
`endif
  endtask

  task automatic test_reset_mid_write;
    poke_word(10'h020, 32'h80FF_7F01);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 10'h021; req_wdata = 32'h0000_00AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++; if (mem_read !== 1'b1) begin n_fail++;
      $display("FAIL rmw_rd: mem_read=%b required 1", mem_read); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (mem_write !== 1'b0) begin n_fail++;
      $display("FAIL rmw_gate: mem_write=%b required 0", mem_write); end
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL rmw_idle: valid=%b ready=%b required 0 1", resp_valid, req_ready); end
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++;
      $display("FAIL rmw_nopulse: resp_valid=%b required 0", resp_valid); end
    n_checks++;
    if ({mem[32], mem[33], mem[34], mem[35]} !== 32'h80FF_7F01) begin n_fail++;
      $display("FAIL rmw_mem: got %h required 80ff7f01", {mem[32], mem[33], mem[34], mem[35]});
    end
  endtask

  task automatic test_back_to_back;
    do_op(1'b1, 2'b10, 1'b0, 10'h040, 32'h1234_5678, 1'b1);
    n_checks++; if (nwr != 1 || wr_addr !== 10'h040) begin n_fail++;
      $display("FAIL b2b_store: wr=%0d addr=%h required 1 040", nwr, wr_addr); end
    do_op(1'b0, 2'b01, 1'b0, 10'h042, 32'h0, 1'b1);
    n_checks++; if (rdata !== 32'h0000_5678 || nwr != 0) begin n_fail++;
      $display("FAIL b2b_load: rdata=%h wr=%0d required 00005678 0", rdata, nwr); end
  endtask

  task automatic test_random;
    logic we, sgn;
    logic [1:0] size;
    logic [AW-1:0] addr, exp_maddr;
    logic [31:0] wdata, exp_rdata;
    bit mis, trapped, noise;
    int exp_lat, exp_nrd, exp_nwr, bad;
    for (int i = 0; i < 1024; i++) begin mem[i] = 8'($urandom); ref_mem[i] = mem[i]; end
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom); size = 2'($urandom); sgn = 1'($urandom); wdata = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 10'h3FC + 10'($urandom_range(0, 3));
      else                           addr = 10'($urandom_range(0, 47));
      noise     = ($urandom_range(0, 3) == 0);
      mis       = model_misaligned(size, addr);
      trapped   = TRAP && mis;
      exp_rdata = (trapped || we) ? 32'h0 : model_load(size, sgn, addr);
      exp_lat   = trapped ? 1 : (we && size[1]) ? 2 : we ? 3 : 2;
      exp_nrd   = (trapped || (we && size[1])) ? 0 : 1;
      exp_nwr   = (!trapped && we) ? 1 : 0;
      exp_maddr = mis ? addr : {addr[AW-1:2], 2'b00};
      do_op(we, size, sgn, addr, wdata, noise);
      n_checks++;
      if (rdata !== exp_rdata || err !== trapped || lat != exp_lat) begin n_fail++;
        $display("FAIL rand_resp[%0d]: rdata=%h err=%b lat=%0d required %h %b %0d", n, rdata,
                 err, lat, exp_rdata, trapped, exp_lat); end
      n_checks++;
      if (nrd != exp_nrd || nwr != exp_nwr) begin n_fail++;
        $display("FAIL rand_bus[%0d]: rd=%0d wr=%0d required %0d %0d", n, nrd, nwr, exp_nrd,
                 exp_nwr); end
      n_checks++;
      if ((nrd > 0 && rd_addr !== exp_maddr) || (nwr > 0 && wr_addr !== exp_maddr)) begin
        n_fail++;
        $display("FAIL rand_addr[%0d]: rd=%h wr=%h required %h", n, rd_addr, wr_addr, exp_maddr);
      end
      if (we && !trapped) model_store(size, addr, wdata);
    end
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    n_checks++;
    if (bad != 0) begin n_fail++;
      $display("FAIL rand_mem: %0d bytes differ, required 0", bad); end
  endtask

  initial begin
    test_reset;
    test_loads;
    test_subword_store;
    test_word_store;
    test_misaligned;
    test_reset_mid_write;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
